task2_driver: RTL and testbench

Initiator side of the task2 start/done compute handshake. Walks an 8-bit operand range `n_first..n_last` and issues each value to a task2-style engine on `N` with a one-cycle `start` pulse. For each operand it waits for `done`, captures `R`, and presents an (operand, result) pair on a valid/ready result port. It sits between a host/controller and the compute engine, replacing hand-driven `start`/`N` sequencing.

---
 rtl/task2_driver.sv | 153 +++++++++++++++
 tb/tb_task2_driver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task2_driver.sv
// Initiator for the task2 start/done engine: walks n_first..n_last, issues each
// operand with a start pulse and presents (operand, result) pairs on a valid/ready port.
module task2_driver #(
  parameter int TIMEOUT = 255,
  parameter int GUARD   = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       go,
  input  logic [7:0] n_first,
  input  logic [7:0] n_last,
  output logic       start,
  output logic [7:0] N,
  input  logic       done,
  input  logic [7:0] R,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_n,
  output logic [7:0] res_r,
  output logic       busy,
  output logic       finished,
  output logic [8:0] count,
  output logic       err_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] GuardMin    = 16'(GUARD);

  state_t      state_q;
  logic [7:0]  cur_q;
  logic [7:0]  last_q;
  logic [15:0] wait_q;
  logic        start_q;
  logic [7:0]  n_q;
  logic        res_valid_q;
  logic [7:0]  res_n_q;
  logic [7:0]  res_r_q;
  logic        busy_q;
  logic        finished_q;
  logic [8:0]  count_q;
  logic        err_q;

  logic        doneAccept;
  logic [7:0]  cur_d;
  logic [8:0]  count_d;

  // A done seen inside the guard window is a leftover from the previous operand.
  assign doneAccept = done && (wait_q >= GuardMin);
  assign cur_d      = cur_q + 8'd1;
  assign count_d    = count_q + 9'd1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      cur_q       <= 8'd0;
      last_q      <= 8'd0;
      wait_q      <= 16'd0;
      start_q     <= 1'b0;
      n_q         <= 8'd0;
      res_valid_q <= 1'b0;
      res_n_q     <= 8'd0;
      res_r_q     <= 8'd0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      count_q     <= 9'd0;
      err_q       <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      finished_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            last_q  <= n_last;
            cur_q   <= n_first;
            count_q <= 9'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (n_first > n_last) begin
              state_q    <= FINISH;
              finished_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              start_q <= 1'b1;
              n_q     <= n_first;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wait_q  <= 16'd0;
        end
        WAIT: begin
          wait_q <= wait_q + 16'd1;
          if (doneAccept) begin
            res_r_q     <= R;
            res_n_q     <= cur_q;
            res_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else if (wait_q == TimeoutLast) begin
            err_q      <= 1'b1;
            finished_q <= 1'b1;
            state_q    <= FINISH;
          end
        end
        EMIT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            count_q     <= count_d;
            // Compare before incrementing so a range ending at 255 never wraps.
            if (cur_q == last_q) begin
              finished_q <= 1'b1;
              state_q    <= FINISH;
            end else begin
              cur_q   <= cur_d;
              n_q     <= cur_d;
              start_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start       = start_q;
  assign N           = n_q;
  assign res_valid   = res_valid_q;
  assign res_n       = res_n_q;
  assign res_r       = res_r_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign count       = count_q;
  assign err_timeout = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_task2_driver.sv
// Self-checking bench for task2_driver: behavioural engine (R = N+1, 6-cycle latency),
// valid/ready consumer with optional stalls, and a queue of expected pairs.
module tb_task2_driver;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       go = 1'b0;
  logic [7:0] n_first = 8'd0;
  logic [7:0] n_last = 8'd0;
  logic       start;
  logic [7:0] N;
  logic       done = 1'b0;
  logic [7:0] R = 8'd0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_n;
  logic [7:0] res_r;
  logic       busy;
  logic       finished;
  logic [8:0] count;
  logic       err_timeout;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ[$];
  bit          holdMode = 1'b0;
  bit          neverDone = 1'b0;
  int          bp = 0;
  int          startCount = 0;
  int          waitCycles = 0;

  int          lat = 0;
  int          stale = 0;
  int          stallLeft = 0;
  logic [7:0]  opN = 8'd0;
  logic        prevValid = 1'b0;
  logic [7:0]  heldN = 8'd0;
  logic [7:0]  heldR = 8'd0;
  logic [15:0] expPair;

  task2_driver #(.TIMEOUT(20), .GUARD(2)) dut (
    .clk(clk), .resetb(resetb), .go(go), .n_first(n_first), .n_last(n_last),
    .start(start), .N(N), .done(done), .R(R),
    .res_valid(res_valid), .res_ready(res_ready), .res_n(res_n), .res_r(res_r),
    .busy(busy), .finished(finished), .count(count), .err_timeout(err_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Engine model, consumer and pair scoreboard all act on the falling edge.
  always @(negedge clk) begin
    if (!resetb) begin
      done = 1'b0;
      lat = 0;
      stale = 0;
      prevValid = 1'b0;
    end else begin
      if (start === 1'b1) begin
        checks++;
        if (res_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL start_during_valid res_valid=%b required 0", res_valid);
        end
        startCount++;
        opN = N;
        lat = neverDone ? 0 : 6;
        stale = holdMode ? 2 : 0;
        if (!holdMode) done = 1'b0;
      end else begin
        if (stale > 0) begin
          stale--;
          if (stale == 0) done = 1'b0;
        end
        if (!holdMode && done) done = 1'b0;
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            done = 1'b1;
            R = opN + 8'd1;
          end
        end
      end
      if (state === 3'd2) waitCycles++;
      if (res_valid === 1'b1) begin
        if (!prevValid) begin
          stallLeft = bp;
          heldN = res_n;
          heldR = res_r;
        end else begin
          checks++;
          if (res_n !== heldN || res_r !== heldR) begin
            errors++;
            $display("[TB] FAIL hold_stable got n=%0d r=%0d required n=%0d r=%0d",
                     res_n, res_r, heldN, heldR);
          end
        end
        if (stallLeft > 0) begin
          res_ready = 1'b0;
          stallLeft--;
        end else begin
          res_ready = 1'b1;
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL pair_unexpected got n=%0d r=%0d required none", res_n, res_r);
          end else begin
            expPair = expQ.pop_front();
            if ({res_n, res_r} !== expPair) begin
              errors++;
              $display("[TB] FAIL pair got n=%0d r=%0d required n=%0d r=%0d",
                       res_n, res_r, expPair[15:8], expPair[7:0]);
            end
          end
        end
      end else begin
        res_ready = (bp == 0);
      end
      prevValid = res_valid;
    end
  end

  task automatic runRange(input logic [7:0] first, input logic [7:0] last, input bit push,
                          output bit sawFinish, output logic issueStart,
                          output logic [7:0] issueN, output logic issueErr,
                          output logic [8:0] endCount, output logic endErr);
    @(negedge clk);
    n_first = first;
    n_last = last;
    go = 1'b1;
    startCount = 0;
    waitCycles = 0;
    if (push)
      for (int i = int'(first); i <= int'(last); i++)
        expQ.push_back({8'(i), 8'(i + 1)});
    @(negedge clk);
    go = 1'b0;
    issueStart = start;
    issueN = N;
    issueErr = err_timeout;
    sawFinish = 1'b0;
    for (int c = 0; c < 2000 && !sawFinish; c++) begin
      if (finished === 1'b1) sawFinish = 1'b1;
      else @(negedge clk);
    end
    endCount = count;
    endErr = err_timeout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({start, N, res_valid, res_n, res_r, busy, finished, count, err_timeout, state} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values got start=%b N=%0d v=%b busy=%b cnt=%0d err=%b state=%0d required all 0",
               start, N, res_valid, busy, count, err_timeout, state);
    end
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    runRange(8'd7, 8'd9, 1'b1, ok, is, in, ie, ec, ee);
    checks++;
    if (is !== 1'b1 || in !== 8'd7) begin
      errors++;
      $display("[TB] FAIL basic_issue got start=%b N=%0d required start=1 N=7", is, in);
    end
    checks++;
    if (!ok || ec !== 9'd3 || ee !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_end got fin=%b count=%0d err=%b required fin=1 count=3 err=0", ok, ec, ee);
    end
    checks++;
    if (startCount != 3 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_starts got starts=%0d left=%0d required starts=3 left=0",
               startCount, expQ.size());
    end
    checks++;
    if (finished !== 1'b0 || state !== 3'd0 || busy !== 1'b0 || count !== 9'd3) begin
      errors++;
      $display("[TB] FAIL basic_idle got fin=%b state=%0d busy=%b count=%0d required 0 0 0 3",
               finished, state, busy, count);
    end
  endtask

  task automatic test_stale_done();
    bit ok; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    holdMode = 1'b1;
    runRange(8'd16, 8'd17, 1'b1, ok, is, in, ie, ec, ee);
    checks++;
    if (!ok || ec !== 9'd2 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL stale_end got fin=%b count=%0d left=%0d required fin=1 count=2 left=0",
               ok, ec, expQ.size());
    end
    holdMode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    bp = 10;
    runRange(8'd40, 8'd42, 1'b1, ok, is, in, ie, ec, ee);
    checks++;
    if (!ok || ec !== 9'd3 || startCount != 3 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_end got fin=%b count=%0d starts=%0d left=%0d required 1 3 3 0",
               ok, ec, startCount, expQ.size());
    end
    bp = 0;
    @(negedge clk);
  endtask

  task automatic test_top_range();
    bit ok; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    runRange(8'd254, 8'd255, 1'b1, ok, is, in, ie, ec, ee);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || ec !== 9'd2 || startCount != 2 || expQ.size() != 0 || state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL top_range got fin=%b count=%0d starts=%0d left=%0d state=%0d required 1 2 2 0 0",
               ok, ec, startCount, expQ.size(), state);
    end
  endtask

  task automatic test_empty_range();
    bit ok; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    runRange(8'd5, 8'd3, 1'b1, ok, is, in, ie, ec, ee);
    checks++;
    if (!ok || ec !== 9'd0 || startCount != 0 || is !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_range got fin=%b count=%0d starts=%0d required fin=1 count=0 starts=0",
               ok, ec, startCount);
    end
  endtask

  task automatic test_timeout();
    bit ok; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    neverDone = 1'b1;
    runRange(8'd100, 8'd101, 1'b0, ok, is, in, ie, ec, ee);
    checks++;
    if (!ok || ee !== 1'b1 || ec !== 9'd0) begin
      errors++;
      $display("[TB] FAIL timeout_end got fin=%b err=%b count=%0d required fin=1 err=1 count=0", ok, ee, ec);
    end
    checks++;
    if (waitCycles != 20 || startCount != 1) begin
      errors++;
      $display("[TB] FAIL timeout_cycles got wait=%0d starts=%0d required wait=20 starts=1",
               waitCycles, startCount);
    end
    neverDone = 1'b0;
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_sticky got err=%b required 1", err_timeout);
    end
    runRange(8'd3, 8'd3, 1'b1, ok, is, in, ie, ec, ee);
    checks++;
    if (ie !== 1'b0 || ee !== 1'b0 || ec !== 9'd1 || !ok) begin
      errors++;
      $display("[TB] FAIL timeout_clear got err_issue=%b err_end=%b count=%0d required 0 0 1", ie, ee, ec);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok; bit inWait; logic is; logic [7:0] in; logic ie; logic [8:0] ec; logic ee;
    @(negedge clk);
    n_first = 8'd30;
    n_last = 8'd32;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    inWait = 1'b0;
    for (int c = 0; c < 50 && !inWait; c++) begin
      if (state === 3'd2) inWait = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!inWait) begin
      errors++;
      $display("[TB] FAIL midrun_wait got state=%0d required 2", state);
    end
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({start, N, res_valid, res_n, res_r, busy, finished, count, err_timeout, state} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset got N=%0d busy=%b cnt=%0d state=%0d required all 0",
               N, busy, count, state);
    end
    expQ.delete();
    @(negedge clk);
    resetb = 1'b1;
    runRange(8'd30, 8'd31, 1'b1, ok, is, in, ie, ec, ee);
    checks++;
    if (is !== 1'b1 || in !== 8'd30 || !ok || ec !== 9'd2 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midrun_restart got N=%0d fin=%b count=%0d left=%0d required N=30 fin=1 count=2 left=0",
               in, ok, ec, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_done();
    test_backpressure();
    test_top_range();
    test_empty_range();
    test_timeout();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
